// File: rtl/sva_thread_sched_if.sv
// Evaluator channel: one request out, one response back per thread step.
// master = scheduler side, slave = evaluator side.
interface sva_thread_sched_if #(
    parameter int STATE_W = 8,
    parameter int SLOT_W  = 3
);
    logic               ev_req_valid;
    logic               ev_req_ready;
    logic [STATE_W-1:0] ev_req_state;
    logic [SLOT_W-1:0]  ev_req_slot;
    logic               ev_rsp_valid;
    logic [STATE_W-1:0] ev_rsp_state;
    logic               ev_rsp_active;
    logic               ev_rsp_succ;
    logic               ev_rsp_fail;

    modport master (
        output ev_req_valid, ev_req_state, ev_req_slot,
        input  ev_req_ready,
        input  ev_rsp_valid, ev_rsp_state, ev_rsp_active,
        input  ev_rsp_succ, ev_rsp_fail
    );

    modport slave (
        input  ev_req_valid, ev_req_state, ev_req_slot,
        output ev_req_ready,
        output ev_rsp_valid, ev_rsp_state, ev_rsp_active,
        output ev_rsp_succ, ev_rsp_fail
    );
endinterface

// File: rtl/sva_thread_sched.sv
// sva_thread_sched: SVA thread table + sequencer for one shared evaluator.
// Ports: sys_clk/sys_rst_n, tick, clr, ev (evaluator channel, master),
//   busy, succ/fail pulses, succ_cnt/fail_cnt, live_cnt, overflow, tick_miss.
// Optional: SVA_SCHED_AGE_EN retires threads after MAX_AGE evaluations.
module sva_thread_sched #(
    parameter int NUM_SLOTS   = 8,
    parameter int STATE_W     = 8,
    parameter int START_STATE = 0,
    parameter int CNT_W       = 16,
    parameter int MAX_AGE     = 32,
    localparam int SLOT_W     = $clog2(NUM_SLOTS),
    localparam int IDX_W      = SLOT_W + 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                tick,
    input  logic                clr,
    sva_thread_sched_if.master  ev,
    output logic                busy,
    output logic                succ,
    output logic                fail,
    output logic [CNT_W-1:0]    succ_cnt,
    output logic [CNT_W-1:0]    fail_cnt,
    output logic [IDX_W-1:0]    live_cnt,
    output logic                overflow,
    output logic                tick_miss
);
    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_ISSUE, S_WAIT,
        S_SPAWN, S_SP_ISSUE, S_SP_WAIT
    } state_e;

    state_e               st_q, st_d;
    logic [NUM_SLOTS-1:0] valid_q, valid_d;
    logic [NUM_SLOTS-1:0] snap_q, snap_d;
    logic [STATE_W-1:0]   tst_q [NUM_SLOTS];
    logic [STATE_W-1:0]   tst_d [NUM_SLOTS];
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [SLOT_W-1:0]    slot_q, slot_d;
    logic [CNT_W-1:0]     scnt_q, scnt_d, fcnt_q, fcnt_d;
    logic [IDX_W-1:0]     live_q, live_d;
    logic                 succ_q, succ_d, fail_q, fail_d;
    logic                 ovf_q, ovf_d, miss_q, miss_d;

    logic [SLOT_W-1:0] idx_lo, free_idx;
    logic              free_found, aged, retire;
    logic              alloc, freed, wb, spawn_wb;

    assign idx_lo = idx_q[SLOT_W-1:0];
    // A thread ends on any verdict even if the evaluator says active.
    assign retire = ~ev.ev_rsp_active | ev.ev_rsp_succ | ev.ev_rsp_fail;

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = SLOT_W'(i);
            end
        end
    end

    always_comb begin
        st_d     = st_q;
        valid_d  = valid_q;
        snap_d   = snap_q;
        tst_d    = tst_q;
        idx_d    = idx_q;
        slot_d   = slot_q;
        ovf_d    = ovf_q;
        miss_d   = miss_q | (tick & (st_q != S_IDLE));
        alloc    = 1'b0;
        freed    = 1'b0;
        wb       = 1'b0;
        spawn_wb = 1'b0;
        succ_d   = 1'b0;
        fail_d   = 1'b0;
        unique case (st_q)
            S_IDLE: begin
                if (tick) begin
                    snap_d = valid_q;
                    idx_d  = '0;
                    st_d   = S_SCAN;
                end
            end
            S_SCAN: begin
                if (idx_q == IDX_W'(NUM_SLOTS)) begin
                    st_d = S_SPAWN;
                end else if (snap_q[idx_lo] && aged) begin
                    valid_d[idx_lo] = 1'b0;
                    freed  = 1'b1;
                    fail_d = 1'b1;
                    idx_d  = idx_q + IDX_W'(1);
                end else if (snap_q[idx_lo]) begin
                    slot_d = idx_lo;
                    st_d   = S_ISSUE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_ISSUE: begin
                if (ev.ev_req_ready) st_d = S_WAIT;
            end
            S_WAIT: begin
                if (ev.ev_rsp_valid) begin
                    wb            = 1'b1;
                    tst_d[slot_q] = ev.ev_rsp_state;
                    succ_d = ev.ev_rsp_succ & ~ev.ev_rsp_fail;
                    fail_d = ev.ev_rsp_fail;
                    if (retire) begin
                        valid_d[slot_q] = 1'b0;
                        freed = 1'b1;
                    end
                    idx_d = {1'b0, slot_q} + IDX_W'(1);
                    st_d  = S_SCAN;
                end
            end
            S_SPAWN: begin
                if (free_found) begin
                    slot_d = free_idx;
                    st_d   = S_SP_ISSUE;
                end else begin
                    ovf_d = 1'b1;
                    st_d  = S_IDLE;
                end
            end
            S_SP_ISSUE: begin
                if (ev.ev_req_ready) st_d = S_SP_WAIT;
            end
            S_SP_WAIT: begin
                if (ev.ev_rsp_valid) begin
                    wb            = 1'b1;
                    spawn_wb      = 1'b1;
                    tst_d[slot_q] = ev.ev_rsp_state;
                    succ_d = ev.ev_rsp_succ & ~ev.ev_rsp_fail;
                    fail_d = ev.ev_rsp_fail;
                    if (!retire) begin
                        valid_d[slot_q] = 1'b1;
                        alloc = 1'b1;
                    end
                    st_d = S_IDLE;
                end
            end
            default: st_d = S_IDLE;
        endcase

        scnt_d = scnt_q;
        fcnt_d = fcnt_q;
        if (succ_d && scnt_q != '1) scnt_d = scnt_q + CNT_W'(1);
        if (fail_d && fcnt_q != '1) fcnt_d = fcnt_q + CNT_W'(1);
        live_d = live_q + IDX_W'(alloc) - IDX_W'(freed);

        if (clr) begin
            st_d    = S_IDLE;
            valid_d = '0;
            snap_d  = '0;
            tst_d   = '{default: '0};
            idx_d   = '0;
            slot_d  = '0;
            ovf_d   = 1'b0;
            miss_d  = 1'b0;
            succ_d  = 1'b0;
            fail_d  = 1'b0;
            scnt_d  = '0;
            fcnt_d  = '0;
            live_d  = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            st_q    <= S_IDLE;
            valid_q <= '0;
            snap_q  <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) tst_q[i] <= '0;
            idx_q   <= '0;
            slot_q  <= '0;
            scnt_q  <= '0;
            fcnt_q  <= '0;
            live_q  <= '0;
            succ_q  <= 1'b0;
            fail_q  <= 1'b0;
            ovf_q   <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            valid_q <= valid_d;
            snap_q  <= snap_d;
            tst_q   <= tst_d;
            idx_q   <= idx_d;
            slot_q  <= slot_d;
            scnt_q  <= scnt_d;
            fcnt_q  <= fcnt_d;
            live_q  <= live_d;
            succ_q  <= succ_d;
            fail_q  <= fail_d;
            ovf_q   <= ovf_d;
            miss_q  <= miss_d;
        end
    end

`ifdef SVA_SCHED_AGE_EN
    localparam int AGE_W = $clog2(MAX_AGE + 1);
    logic [AGE_W-1:0] age_q [NUM_SLOTS];
    logic [AGE_W-1:0] age_d [NUM_SLOTS];

    assign aged = (age_q[idx_lo] == AGE_W'(MAX_AGE));

    // The spawn write-back is the thread's first evaluation.
    always_comb begin
        age_d = age_q;
        if (wb) begin
            age_d[slot_q] = spawn_wb ? AGE_W'(1)
                                     : age_q[slot_q] + AGE_W'(1);
        end
        if (clr) age_d = '{default: '0};
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) age_q[i] <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`else
    logic unused_age;
    assign aged       = 1'b0;
    assign unused_age = ^{MAX_AGE != 0, wb, spawn_wb};
`endif

    assign ev.ev_req_valid = (st_q == S_ISSUE) || (st_q == S_SP_ISSUE);
    assign ev.ev_req_state = (st_q == S_SP_ISSUE) ? STATE_W'(START_STATE)
                                                  : tst_q[slot_q];
    assign ev.ev_req_slot  = slot_q;
    assign busy      = (st_q != S_IDLE);
    assign succ      = succ_q;
    assign fail      = fail_q;
    assign succ_cnt  = scnt_q;
    assign fail_cnt  = fcnt_q;
    assign live_cnt  = live_q;
    assign overflow  = ovf_q;
    assign tick_miss = miss_q;
endmodule

// File: tb/tb_sva_thread_sched.sv
// tb_sva_thread_sched: directed per-tick vectors with a tiny evaluator model,
// plus a hand sequence for clr during an outstanding request.
module tb_sva_thread_sched;
    localparam int NS = 8;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n, tick, clr;
    logic        busy, succ, fail, overflow, tick_miss;
    logic [15:0] succ_cnt, fail_cnt;
    logic [3:0]  live_cnt;

    sva_thread_sched_if #(.STATE_W(8), .SLOT_W(3)) ev ();

    sva_thread_sched #(
        .NUM_SLOTS(NS), .STATE_W(8), .START_STATE(0),
        .CNT_W(16), .MAX_AGE(4)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .tick(tick), .clr(clr), .ev(ev),
        .busy(busy), .succ(succ), .fail(fail),
        .succ_cnt(succ_cnt), .fail_cnt(fail_cnt),
        .live_cnt(live_cnt), .overflow(overflow),
        .tick_miss(tick_miss)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        bit         clr_b;
        int         hold;
        bit         poke;
        logic [7:0] act, sm, fm;
        bit         sp_act;
        logic [7:0] iss;
        int         sp;
        int         s, f, l;
        bit         ovf, miss;
    } vec_t;

    vec_t tbl[$];
    int checks = 0, errors = 0;
    int n_succ = 0, n_fail = 0, base_s = 0, base_f = 0;
    logic [7:0] mvalid;
    logic [7:0] mstate [NS];

    always @(negedge sys_clk) begin
        if (succ === 1'b1) n_succ++;
        if (fail === 1'b1) n_fail++;
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic vec_t mk(bit c, int h, bit p, logic [7:0] a,
                                logic [7:0] sm, logic [7:0] fm, bit spa,
                                logic [7:0] iss, int sp, int s, int f,
                                int l, bit o, bit m);
        vec_t v;
        v.clr_b = c; v.hold = h; v.poke = p;
        v.act = a; v.sm = sm; v.fm = fm; v.sp_act = spa;
        v.iss = iss; v.sp = sp; v.s = s; v.f = f; v.l = l;
        v.ovf = o; v.miss = m;
        return v;
    endfunction

    task automatic do_clr();
        clr = 1'b1;
        @(posedge sys_clk); #1;
        clr = 1'b0;
        mvalid = '0;
        for (int i = 0; i < NS; i++) mstate[i] = '0;
        base_s = n_succ;
        base_f = n_fail;
    endtask

    task automatic serve_tick(input vec_t v, output logic [7:0] iss,
                              output int sp, output int bad,
                              output bit tmo);
        int s, cyc;
        bit first, a, sc, fl;
        logic [7:0] rs;
        iss = '0; sp = -1; bad = 0; cyc = 0; first = 1'b1;
        tick = 1'b1;
        @(posedge sys_clk); #1;
        tick = 1'b0;
        while (busy && cyc < 300) begin
            if (ev.ev_req_valid) begin
                s  = int'(ev.ev_req_slot);
                rs = ev.ev_req_state;
                if (rs == 8'd0) begin
                    sp = s; a = v.sp_act; sc = 1'b0; fl = 1'b0;
                end else begin
                    iss[s] = 1'b1;
                    if (!mvalid[s] || rs != mstate[s]) bad++;
                    a = v.act[s]; sc = v.sm[s]; fl = v.fm[s];
                end
                if (first) begin
                    for (int k = 0; k < v.hold; k++) begin
                        if (k == 0 && v.poke) tick = 1'b1;
                        @(posedge sys_clk); #1;
                        tick = 1'b0;
                        if (ev.ev_req_valid !== 1'b1 ||
                            int'(ev.ev_req_slot) != s ||
                            ev.ev_req_state !== rs) bad++;
                    end
                    cyc += v.hold;
                end
                first = 1'b0;
                ev.ev_req_ready = 1'b1;
                @(posedge sys_clk); #1;
                ev.ev_req_ready  = 1'b0;
                ev.ev_rsp_valid  = 1'b1;
                ev.ev_rsp_state  = rs + 8'd1;
                ev.ev_rsp_active = a;
                ev.ev_rsp_succ   = sc;
                ev.ev_rsp_fail   = fl;
                @(posedge sys_clk); #1;
                ev.ev_rsp_valid  = 1'b0;
                ev.ev_rsp_succ   = 1'b0;
                ev.ev_rsp_fail   = 1'b0;
                mstate[s] = rs + 8'd1;
                mvalid[s] = a && !sc && !fl;
                cyc += 2;
            end else begin
                @(posedge sys_clk); #1;
                cyc++;
            end
        end
        tmo = busy;
        @(posedge sys_clk); #1;
    endtask

    initial begin
        vec_t v;
        logic [7:0] iss;
        int sp, bad, cyc;
        bit tmo;

        sys_rst_n = 1'b0; tick = 1'b0; clr = 1'b0;
        ev.ev_req_ready = 1'b0; ev.ev_rsp_valid = 1'b0;
        ev.ev_rsp_state = '0; ev.ev_rsp_active = 1'b0;
        ev.ev_rsp_succ = 1'b0; ev.ev_rsp_fail = 1'b0;
        mvalid = '0;
        for (int i = 0; i < NS; i++) mstate[i] = '0;

`ifdef SVA_SCHED_AGE_EN
        tbl.push_back(mk(0,0,0,8'h00,0,0,1,8'h00,0,0,0,1,0,0));
        tbl.push_back(mk(0,0,0,8'h01,0,0,0,8'h01,1,0,0,1,0,0));
        tbl.push_back(mk(0,0,0,8'h01,0,0,0,8'h01,1,0,0,1,0,0));
        tbl.push_back(mk(0,0,0,8'h01,0,0,0,8'h01,1,0,0,1,0,0));
        tbl.push_back(mk(0,0,0,8'h01,0,0,0,8'h00,0,0,1,0,0,0));
`else
        // single thread: spawn, active, succ (spawns after t1 die)
        tbl.push_back(mk(0,0,0,8'h00,0,0,1,8'h00,0,0,0,1,0,0));
        tbl.push_back(mk(0,0,0,8'h01,0,0,0,8'h01,1,0,0,1,0,0));
        tbl.push_back(mk(0,0,0,8'h01,8'h01,0,0,8'h01,0,1,0,0,0,0));
        // three threads, middle one fails, slot 1 reused
        tbl.push_back(mk(0,0,0,8'h00,0,0,1,8'h00,0,1,0,1,0,0));
        tbl.push_back(mk(0,0,0,8'h01,0,0,1,8'h01,1,1,0,2,0,0));
        tbl.push_back(mk(0,0,0,8'h03,0,0,1,8'h03,2,1,0,3,0,0));
        tbl.push_back(mk(0,0,0,8'h07,0,8'h02,1,8'h07,1,1,1,3,0,0));
        tbl.push_back(mk(0,0,0,8'h07,0,0,0,8'h07,3,1,1,3,0,0));
        // succ and fail together count as fail only
        tbl.push_back(mk(0,0,0,8'h07,8'h01,8'h01,0,8'h07,0,1,2,2,0,0));
        // fill the table, ninth tick overflows
        tbl.push_back(mk(1,0,0,8'hFF,0,0,1,8'h00,0,0,0,1,0,0));
        tbl.push_back(mk(0,0,0,8'hFF,0,0,1,8'h01,1,0,0,2,0,0));
        tbl.push_back(mk(0,0,0,8'hFF,0,0,1,8'h03,2,0,0,3,0,0));
        tbl.push_back(mk(0,0,0,8'hFF,0,0,1,8'h07,3,0,0,4,0,0));
        tbl.push_back(mk(0,0,0,8'hFF,0,0,1,8'h0F,4,0,0,5,0,0));
        tbl.push_back(mk(0,0,0,8'hFF,0,0,1,8'h1F,5,0,0,6,0,0));
        tbl.push_back(mk(0,0,0,8'hFF,0,0,1,8'h3F,6,0,0,7,0,0));
        tbl.push_back(mk(0,0,0,8'hFF,0,0,1,8'h7F,7,0,0,8,0,0));
        tbl.push_back(mk(0,0,0,8'hFF,0,0,1,8'hFF,-1,0,0,8,1,0));
        // tick while busy, request held 10 cycles
        tbl.push_back(mk(1,0,0,8'h00,0,0,1,8'h00,0,0,0,1,0,0));
        tbl.push_back(mk(0,10,1,8'h01,0,0,1,8'h01,1,0,0,2,0,1));
`endif

        repeat (3) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_succ_cnt", succ_cnt, 0);
        chk("rst_fail_cnt", fail_cnt, 0);
        chk("rst_live", live_cnt, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_miss", tick_miss, 0);
        chk("rst_req_valid", ev.ev_req_valid, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            if (v.clr_b) do_clr();
            serve_tick(v, iss, sp, bad, tmo);
            chk($sformatf("v%0d_timeout", i), tmo, 0);
            chk($sformatf("v%0d_issued", i), iss, v.iss);
            chk($sformatf("v%0d_spawn_slot", i), sp, v.sp);
            chk($sformatf("v%0d_req_bad", i), bad, 0);
            chk($sformatf("v%0d_succ_cnt", i), succ_cnt, v.s);
            chk($sformatf("v%0d_fail_cnt", i), fail_cnt, v.f);
            chk($sformatf("v%0d_succ_pulses", i), n_succ - base_s, v.s);
            chk($sformatf("v%0d_fail_pulses", i), n_fail - base_f, v.f);
            chk($sformatf("v%0d_live", i), live_cnt, v.l);
            chk($sformatf("v%0d_ovf", i), overflow, v.ovf);
            chk($sformatf("v%0d_miss", i), tick_miss, v.miss);
        end

        // clr while a request is outstanding; late response ignored
        tick = 1'b1;
        @(posedge sys_clk); #1;
        tick = 1'b0;
        cyc = 0;
        while (ev.ev_req_valid !== 1'b1 && cyc < 20) begin
            @(posedge sys_clk); #1;
            cyc++;
        end
        chk("clrw_req_seen", ev.ev_req_valid, 1);
        ev.ev_req_ready = 1'b1;
        @(posedge sys_clk); #1;
        ev.ev_req_ready = 1'b0;
        do_clr();
        ev.ev_rsp_valid  = 1'b1;
        ev.ev_rsp_state  = 8'h55;
        ev.ev_rsp_active = 1'b1;
        ev.ev_rsp_succ   = 1'b1;
        ev.ev_rsp_fail   = 1'b1;
        @(posedge sys_clk); #1;
        ev.ev_rsp_valid = 1'b0;
        ev.ev_rsp_succ  = 1'b0;
        ev.ev_rsp_fail  = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        chk("clrw_busy", busy, 0);
        chk("clrw_succ_cnt", succ_cnt, 0);
        chk("clrw_fail_cnt", fail_cnt, 0);
        chk("clrw_pulses", (n_succ - base_s) + (n_fail - base_f), 0);
        chk("clrw_live", live_cnt, 0);
        chk("clrw_ovf", overflow, 0);
        chk("clrw_miss", tick_miss, 0);
        v = mk(0,0,0,8'h00,0,0,0,8'h00,0,0,0,0,0,0);
        serve_tick(v, iss, sp, bad, tmo);
        chk("clrw_empty_timeout", tmo, 0);
        chk("clrw_empty_issued", iss, 8'h00);
        chk("clrw_empty_spawn", sp, 0);
        chk("clrw_empty_live", live_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
